// File: rtl/turn_scheduler.sv
// Turn/flight/settle sequencer for one board of the cat/dog match.
// Optional TURN_AIM_TIMEOUT_EN: auto-throw after AIM_TIMEOUT_FRAMES of aiming.
module turn_scheduler #(
    parameter int AIM_TIMEOUT_FRAMES    = 600,
    parameter int FLIGHT_TIMEOUT_FRAMES = 480,
    parameter int SETTLE_FRAMES         = 60
) (
    input  logic       clk60MHz,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       player1_ready,
    input  logic       player2_ready,
    input  logic [1:0] current_player,
    input  logic       left,
    input  logic       in_throw_flag,
    input  logic       end_throw,
    input  logic [6:0] hp_player1,
    input  logic [6:0] hp_player2,
    output logic [2:0] turn,
    output logic       local_turn,
    output logic       aim_en,
    output logic       throw_flag,
    output logic       flight_timeout,
    output logic [1:0] winner,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'b000,
        S_WAIT_READY = 3'b001,
        S_AIM_LOCAL  = 3'b010,
        S_AIM_REMOTE = 3'b011,
        S_FLIGHT     = 3'b100,
        S_SETTLE     = 3'b101,
        S_GAME_OVER  = 3'b110
    } state_t;

    // The shared frame counter is 10 bits wide; every threshold must fit.
    if (AIM_TIMEOUT_FRAMES < 1 || AIM_TIMEOUT_FRAMES > 1023 ||
        FLIGHT_TIMEOUT_FRAMES < 1 || FLIGHT_TIMEOUT_FRAMES > 1023 ||
        SETTLE_FRAMES < 1 || SETTLE_FRAMES > 1023) begin : g_bad_cfg
        $error("turn_scheduler: frame threshold out of range");
    end

    localparam logic [9:0] FLIGHT_LIM = 10'(FLIGHT_TIMEOUT_FRAMES);
    localparam logic [9:0] SETTLE_LIM = 10'(SETTLE_FRAMES);

    state_t     state_q, state_d;
    logic [2:0] turn_q, turn_d;
    logic       local_turn_q, local_turn_d;
    logic       aim_en_q, aim_en_d;
    logic       throw_flag_q, throw_flag_d;
    logic       flight_timeout_q, flight_timeout_d;
    logic [1:0] winner_q, winner_d;
    logic [9:0] cnt_q, cnt_d;
    logic       left_q, in_throw_q;

    logic       both_ready, role_ok, left_fall, throw_rise, aim_done;
    logic       hp_zero;
    logic [2:0] turn_inc;

    function automatic logic is_local(input logic [2:0] t, input logic [1:0] r);
        return (~t[0] & (r == 2'b01)) | (t[0] & (r == 2'b10));
    endfunction

    assign both_ready = player1_ready & player2_ready;
    assign role_ok    = (current_player == 2'b01) | (current_player == 2'b10);
    assign left_fall  = left_q & ~left;
    assign throw_rise = ~in_throw_q & in_throw_flag;
    assign hp_zero    = (hp_player1 == 7'd0) | (hp_player2 == 7'd0);
    assign turn_inc   = turn_q + 3'd1;

`ifdef TURN_AIM_TIMEOUT_EN
    localparam logic [9:0] AIM_LIM = 10'(AIM_TIMEOUT_FRAMES);
    assign aim_done = left_fall | (cnt_q >= AIM_LIM);
`else
    assign aim_done = left_fall;
`endif

    always_comb begin
        state_d          = state_q;
        turn_d           = turn_q;
        throw_flag_d     = throw_flag_q;
        flight_timeout_d = flight_timeout_q;
        winner_d         = winner_q;
        case (state_q)
            S_IDLE: state_d = S_WAIT_READY;
            S_WAIT_READY: begin
                if (both_ready && role_ok) begin
                    state_d = is_local(turn_q, current_player) ? S_AIM_LOCAL : S_AIM_REMOTE;
                end
            end
            S_AIM_LOCAL: begin
                if (!both_ready) begin
                    state_d = S_WAIT_READY;
                end else if (aim_done) begin
                    state_d      = S_FLIGHT;
                    throw_flag_d = 1'b1;
                end
            end
            S_AIM_REMOTE: begin
                if (!both_ready) begin
                    state_d = S_WAIT_READY;
                end else if (throw_rise) begin
                    state_d = S_FLIGHT;
                end
            end
            S_FLIGHT: begin
                if (end_throw) begin
                    state_d          = S_SETTLE;
                    flight_timeout_d = 1'b0;
                    throw_flag_d     = 1'b0;
                end else if (cnt_q >= FLIGHT_LIM) begin
                    state_d          = S_SETTLE;
                    flight_timeout_d = 1'b1;
                    throw_flag_d     = 1'b0;
                end
            end
            S_SETTLE: begin
                if (cnt_q >= SETTLE_LIM) begin
                    if (hp_zero) begin
                        state_d  = S_GAME_OVER;
                        winner_d = {hp_player1 == 7'd0, hp_player2 == 7'd0};
                    end else begin
                        turn_d  = turn_inc;
                        state_d = is_local(turn_inc, current_player) ? S_AIM_LOCAL : S_AIM_REMOTE;
                    end
                end
            end
            S_GAME_OVER: state_d = S_GAME_OVER;
            default: state_d = S_IDLE;
        endcase

        local_turn_d = (state_d == S_AIM_LOCAL);
        aim_en_d     = (state_d == S_AIM_LOCAL);

        // Counter restarts on every state entry and saturates at full scale.
        if (state_d != state_q) begin
            cnt_d = 10'd0;
        end else if (frame_tick && cnt_q != 10'h3FF) begin
            cnt_d = cnt_q + 10'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            state_q          <= S_IDLE;
            turn_q           <= 3'd0;
            local_turn_q     <= 1'b0;
            aim_en_q         <= 1'b0;
            throw_flag_q     <= 1'b0;
            flight_timeout_q <= 1'b0;
            winner_q         <= 2'b00;
            cnt_q            <= 10'd0;
            left_q           <= 1'b0;
            in_throw_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            turn_q           <= turn_d;
            local_turn_q     <= local_turn_d;
            aim_en_q         <= aim_en_d;
            throw_flag_q     <= throw_flag_d;
            flight_timeout_q <= flight_timeout_d;
            winner_q         <= winner_d;
            cnt_q            <= cnt_d;
            left_q           <= left;
            in_throw_q       <= in_throw_flag;
        end
    end

    assign turn           = turn_q;
    assign local_turn     = local_turn_q;
    assign aim_en         = aim_en_q;
    assign throw_flag     = throw_flag_q;
    assign flight_timeout = flight_timeout_q;
    assign winner         = winner_q;
    assign state          = state_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with a behavioural game-flow model.
// Honours TURN_AIM_TIMEOUT_EN the same way the design does.
module tb_turn_scheduler;

    logic       clk60MHz = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       player1_ready = 1'b0;
    logic       player2_ready = 1'b0;
    logic [1:0] current_player = 2'b00;
    logic       left = 1'b0;
    logic       in_throw_flag = 1'b0;
    logic       end_throw = 1'b0;
    logic [6:0] hp_player1 = 7'd100;
    logic [6:0] hp_player2 = 7'd100;
    logic [2:0] turn;
    logic       local_turn;
    logic       aim_en;
    logic       throw_flag;
    logic       flight_timeout;
    logic [1:0] winner;
    logic [2:0] state;

    turn_scheduler dut (
        .clk60MHz       (clk60MHz),
        .rst            (rst),
        .frame_tick     (frame_tick),
        .player1_ready  (player1_ready),
        .player2_ready  (player2_ready),
        .current_player (current_player),
        .left           (left),
        .in_throw_flag  (in_throw_flag),
        .end_throw      (end_throw),
        .hp_player1     (hp_player1),
        .hp_player2     (hp_player2),
        .turn           (turn),
        .local_turn     (local_turn),
        .aim_en         (aim_en),
        .throw_flag     (throw_flag),
        .flight_timeout (flight_timeout),
        .winner         (winner),
        .state          (state)
    );

    always #5 clk60MHz = ~clk60MHz;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Game-flow model: phase numbers are the debug codes shown on the LEDs.
    localparam int IDLE = 0, WAIT = 1, AIM_L = 2, AIM_R = 3;
    localparam int FLY = 4, SETTLE = 5, OVER = 6;
    localparam int AIM_FRAMES = 600, FLY_FRAMES = 480, SETTLE_FR = 60;

    int m_phase = IDLE;
    int m_turn = 0;
    int m_frames = 0;
    int m_flag = 0;
    int m_timeout = 0;
    int m_winner = 0;
    int m_left_before = 0;
    int m_itf_before = 0;
    int m_next;

    function automatic int mine(input int t, input logic [1:0] role);
        if (role == 2'b01) return (t % 2 == 0) ? 1 : 0;
        if (role == 2'b10) return (t % 2 == 1) ? 1 : 0;
        return 0;
    endfunction

    function automatic int aim_expired(input int frames);
`ifdef TURN_AIM_TIMEOUT_EN
        return (frames >= AIM_FRAMES) ? 1 : 0;
`else
        return (frames < 0) ? 1 : 0;
`endif
    endfunction

    always @(posedge clk60MHz) begin
        if (rst) begin
            m_phase = IDLE; m_turn = 0; m_frames = 0; m_flag = 0;
            m_timeout = 0; m_winner = 0; m_left_before = 0; m_itf_before = 0;
        end else begin
            m_next = m_phase;
            if (m_phase == IDLE) begin
                m_next = WAIT;
            end else if (m_phase == WAIT) begin
                if (player1_ready && player2_ready &&
                    (current_player == 2'b01 || current_player == 2'b10))
                    m_next = mine(m_turn, current_player) ? AIM_L : AIM_R;
            end else if (m_phase == AIM_L || m_phase == AIM_R) begin
                if (!(player1_ready && player2_ready)) begin
                    m_next = WAIT;
                end else if (m_phase == AIM_L &&
                             ((m_left_before == 1 && left == 0) || aim_expired(m_frames) == 1)) begin
                    m_next = FLY;
                    m_flag = 1;
                end else if (m_phase == AIM_R && m_itf_before == 0 && in_throw_flag == 1) begin
                    m_next = FLY;
                end
            end else if (m_phase == FLY) begin
                if (end_throw) begin
                    m_next = SETTLE; m_timeout = 0; m_flag = 0;
                end else if (m_frames >= FLY_FRAMES) begin
                    m_next = SETTLE; m_timeout = 1; m_flag = 0;
                end
            end else if (m_phase == SETTLE) begin
                if (m_frames >= SETTLE_FR) begin
                    if (hp_player1 == 0 && hp_player2 == 0) begin
                        m_next = OVER; m_winner = 3;
                    end else if (hp_player1 == 0) begin
                        m_next = OVER; m_winner = 2;
                    end else if (hp_player2 == 0) begin
                        m_next = OVER; m_winner = 1;
                    end else begin
                        m_turn = (m_turn + 1) % 8;
                        m_next = mine(m_turn, current_player) ? AIM_L : AIM_R;
                    end
                end
            end
            if (m_next != m_phase) m_frames = 0;
            else if (frame_tick) m_frames = m_frames + 1;
            m_phase = m_next;
            m_left_before = int'(left);
            m_itf_before = int'(in_throw_flag);
        end
    end

    always @(negedge clk60MHz) begin
        chk("state", int'(state), m_phase);
        chk("turn", int'(turn), m_turn);
        chk("local_turn", int'(local_turn), (m_phase == AIM_L) ? 1 : 0);
        chk("aim_en", int'(aim_en), (m_phase == AIM_L) ? 1 : 0);
        chk("throw_flag", int'(throw_flag), m_flag);
        chk("flight_timeout", int'(flight_timeout), m_timeout);
        chk("winner", int'(winner), m_winner);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk60MHz);
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_tick = 1'b1; cyc(1);
            frame_tick = 1'b0; cyc(1);
        end
    endtask

    task automatic click();
        left = 1'b1; cyc(2);
        left = 1'b0; cyc(1);
    endtask

    task automatic remote_throw();
        in_throw_flag = 1'b0; cyc(1);
        in_throw_flag = 1'b1; cyc(1);
    endtask

    task automatic end_pulse();
        end_throw = 1'b1; cyc(1);
        end_throw = 1'b0;
    endtask

    task automatic do_turn();
        if (m_phase == AIM_L) click();
        else remote_throw();
        cyc(2);
        end_pulse();
        frames(60);
    endtask

    initial begin
        // Reset values
        cyc(3);
        chk("rst_state", int'(state), 0);
        chk("rst_turn", int'(turn), 0);
        chk("rst_winner", int'(winner), 0);
        chk("rst_throw_flag", int'(throw_flag), 0);

        // Role cat: ready at cycle 5, local aim on turn 0
        rst = 1'b0;
        current_player = 2'b01;
        cyc(2);
        chk("a_wait_ready", int'(state), 1);
        cyc(3);
        player1_ready = 1'b1;
        player2_ready = 1'b1;
        cyc(2);
        chk("a_aim_local", int'(state), 2);
        chk("a_local_turn", int'(local_turn), 1);
        chk("a_aim_en", int'(aim_en), 1);
        click();
        chk("a_flight", int'(state), 4);
        chk("a_throw_flag", int'(throw_flag), 1);
        cyc(3);
        end_pulse();
        cyc(1);
        chk("a_settle", int'(state), 5);
        chk("a_flag_clr", int'(throw_flag), 0);
        frames(59);
        chk("a_settle_59", int'(state), 5);
        frames(1);
        chk("a_aim_remote", int'(state), 3);
        chk("a_turn1", int'(turn), 1);

        // Remote flight into a player1 knockout
        hp_player1 = 7'd0;
        hp_player2 = 7'd40;
        remote_throw();
        chk("a_remote_flight", int'(state), 4);
        chk("a_remote_noflag", int'(throw_flag), 0);
        end_pulse();
        frames(60);
        chk("a_game_over", int'(state), 6);
        chk("a_winner_dog", int'(winner), 2);
        click();
        cyc(2);
        chk("a_over_hold", int'(state), 6);

        // Role dog: remote turn 0, watchdog ends the flight
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        hp_player1 = 7'd100;
        hp_player2 = 7'd100;
        in_throw_flag = 1'b0;
        current_player = 2'b10;
        cyc(3);
        chk("b_aim_remote", int'(state), 3);
        chk("b_local_turn", int'(local_turn), 0);
        remote_throw();
        chk("b_flight", int'(state), 4);
        frames(479);
        chk("b_flight_479", int'(state), 4);
        frames(1);
        chk("b_settle", int'(state), 5);
        chk("b_timeout", int'(flight_timeout), 1);
        frames(60);
        chk("b_turn1_local", int'(state), 2);
        repeat (4) do_turn();
        chk("b_turn5", int'(turn), 5);
        chk("b_turn5_local", int'(state), 2);

        // Ready drop keeps the turn; resume as cat
        player2_ready = 1'b0;
        cyc(1);
        chk("b_drop_wait", int'(state), 1);
        chk("b_drop_turn", int'(turn), 5);
        current_player = 2'b01;
        player2_ready = 1'b1;
        cyc(1);
        chk("b_resume_remote", int'(state), 3);
        repeat (3) do_turn();
        chk("b_wrap_turn", int'(turn), 0);
        chk("b_wrap_local", int'(state), 2);

        // Aim with no release, then a double knockout
        hp_player1 = 7'd0;
        hp_player2 = 7'd0;
`ifdef TURN_AIM_TIMEOUT_EN
        frames(599);
        chk("c_aim_599", int'(state), 2);
        frames(1);
        chk("c_auto_throw", int'(state), 4);
        chk("c_auto_flag", int'(throw_flag), 1);
`else
        frames(1000);
        chk("c_aim_1000", int'(state), 2);
        click();
        chk("c_click_flag", int'(throw_flag), 1);
`endif
        end_pulse();
        cyc(1);
        chk("c_settle_fto", int'(flight_timeout), 0);
        frames(60);
        chk("c_game_over", int'(state), 6);
        chk("c_winner_draw", int'(winner), 3);
        click();
        click();
        chk("c_over_hold", int'(state), 6);
        rst = 1'b1;
        cyc(2);
        chk("c_rst_again", int'(state), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
